ref_ctl: RTL and testbench
==========================

# ref_ctl

DRAM refresh responder: consumes the refresh-window request pair (RefReq/RefUrg) produced by the timer/reset block and performs exactly one CAS-before-RAS refresh per window on the RAM array. It arbitrates against CPU RAM accesses: it refreshes opportunistically when the bus is idle, and forces a refresh by holding off new RAM accesses once the window turns urgent. It sits beside the RAM access controller, which muxes this block's strobes onto the RAM pins while RefActive is high.

## Interface
Parameters:
- CAS_SETUP, 1: cycles nCASref is low before nRASref falls (1..7).
- RAS_LOW, 3: cycles nRASref is held low (1..7).
- RAS_PRE, 2: RAS precharge cycles after both strobes rise (1..7).

Ports:
- CLK  in  1  FSB clock; all state changes on its rising edge.
- nPOR  in  1  reset; one clock; reset is asynchronous and active-low.
- RefReq  in  1  refresh window open; CLK-synchronous level.
- RefUrg  in  1  window about to close; only meaningful while RefReq=1.
- BACT  in  1  CPU bus cycle active.
- RAMCS  in  1  current bus cycle addresses RAM.
- nRASref  out  1  refresh RAS strobe, active-low.
- nCASref  out  1  refresh CAS strobe, active-low.
- RefActive  out  1  refresh owns the RAM pins (mux select).
- RAMHold  out  1  RAM controller must not start a new access.
- RefDone  out  1  refresh completed in the current window.
- RefMiss  out  8  missed-window count (see Configuration).

## Operation
- All outputs are registered. Reset values: nRASref=1, nCASref=1, RefActive=0, RAMHold=0, RefDone=0, RefMiss=0, state IDLE.
- pending = RefReq && !RefDone. ramidle = !(BACT && RAMCS).
- States: IDLE, WAIT, CAS, RAS, PRE.
- IDLE:
  - pending && !BACT -> CAS (opportunistic).
  - Otherwise pending && RefUrg && ramidle -> CAS.
  - Otherwise pending && RefUrg -> WAIT.
- WAIT: RAMHold=1.
  - ramidle -> CAS.
  - RefReq=0 -> IDLE (abort).
- CAS: nCASref=0, RefActive=1, RAMHold=1 for CAS_SETUP cycles, then -> RAS.
- RAS: nCASref=0, nRASref=0 for RAS_LOW cycles, then -> PRE.
- PRE: both strobes 1, RefActive and RAMHold stay 1 for RAS_PRE cycles, then -> IDLE.
  - On that transition RefDone<=1, RefActive<=0, RAMHold<=0.
- Phase counter: 3 bits, loaded at each phase entry, counts down to 0. Equal parameter values need no special case.
- Window close is the cycle with RefReq=0:
  - RefDone<=0 only when state is IDLE or WAIT. If a refresh is in flight (CAS/RAS/PRE), it completes, and RefDone is cleared on the first IDLE cycle where RefReq=0.
  - A miss is a window close with RefDone=0 and state IDLE/WAIT, evaluated on the first RefReq=0 cycle only (edge of RefReq).
- A CAS/RAS/PRE sequence is never aborted except by nPOR.
- nPOR assertion mid-sequence forces all strobes high immediately (asynchronous).

## Timing
- Decision latency: the state and outputs change on the first rising edge where the entry condition is sampled true. The RAM controller sees RAMHold=1 in the same cycle it could see BACT rise.
- Tie-break: if BACT rises on the same edge a refresh starts, the refresh wins and the RAM access waits on RAMHold.
- Sequence length is CAS_SETUP+RAS_LOW+RAS_PRE cycles; the default is 6.
- nCASref leads nRASref by exactly CAS_SETUP cycles. Both strobes rise together.
- At most one refresh per window. After RefDone=1, a still-high RefReq causes no further cycles.

## Configuration
- REF_MISS_CNT_EN defined: RefMiss is an 8-bit counter incrementing per missed window and saturating at 255. Cleared only by nPOR.
- REF_MISS_CNT_EN undefined: RefMiss is tied to 0 and no counter logic is built.

## Structure
- Package ref_pkg: state enum (IDLE, WAIT, CAS, RAS, PRE), default timing constants, and the 3-bit phase-counter width.
- One natural sub-module, ref_miss_cnt: RefReq edge detect plus the saturating counter. It is instantiated only under REF_MISS_CNT_EN.

## Test plan
- Idle refresh: BACT=0, RefReq rises -> next edge nCASref=0; 1 cycle later nRASref=0 for 3 cycles; 2 PRE cycles; RefDone=1 after 6 cycles; no second sequence while RefReq stays 1.
- Urgent during RAM access: BACT=RAMCS=1 held, RefReq=1, RefUrg=1 -> WAIT with RAMHold=1 and strobes high. Drop RAMCS -> CAS on the next edge.
- Urgent during I/O access: BACT=1, RAMCS=0, RefUrg=1 -> refresh starts immediately without WAIT.
- Missed window: BACT=1, RAMCS=1 for the whole window with RefUrg=0 -> no refresh; RefMiss increments 0->1 with the macro defined and stays 0 without it. 300 misses saturate at 255.
- Window closes mid-refresh: RefReq falls during RAS -> sequence completes, no miss counted, RefDone returns to 0. The next window refreshes normally.
- Reset mid-RAS: nPOR low -> nRASref=nCASref=1 and RefActive=0 with no clock edge. After release, state is IDLE.

Source files
------------

// File: rtl/ref_pkg.sv
// Shared types and timing defaults for the DRAM refresh responder (ref_ctl).
package ref_pkg;

    localparam int CNT_W         = 3;
    localparam int CAS_SETUP_DEF = 1;
    localparam int RAS_LOW_DEF   = 3;
    localparam int RAS_PRE_DEF   = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CAS,
        RAS,
        PRE
    } ref_state_e;

    // A phase lasting N cycles is loaded with N-1 and leaves when the counter reads 0.
    function automatic logic [CNT_W-1:0] phase_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ref_miss_cnt.sv
// Missed-refresh-window counter: RefReq falling-edge detect plus an 8-bit saturating count.
module ref_miss_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ref_req_i,
    input  logic       miss_ok_i,
    output logic [7:0] miss_cnt_o
);

    logic       req_q;
    logic [7:0] cnt_q, cnt_d;
    logic       miss;

    // A window is missed when it closes while no refresh is done or in flight.
    assign miss = req_q && !ref_req_i && miss_ok_i;

    always_comb begin
        cnt_d = cnt_q;
        if (miss && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            req_q <= ref_req_i;
            cnt_q <= cnt_d;
        end
    end

    assign miss_cnt_o = cnt_q;

endmodule

// File: rtl/ref_ctl.sv
// DRAM CAS-before-RAS refresh responder, one refresh per RefReq window.
// Optional missed-window counter enabled by defining REF_MISS_CNT_EN.
module ref_ctl
    import ref_pkg::*;
#(
    parameter int CAS_SETUP = CAS_SETUP_DEF,
    parameter int RAS_LOW   = RAS_LOW_DEF,
    parameter int RAS_PRE   = RAS_PRE_DEF
) (
    input  logic       CLK,
    input  logic       nPOR,
    input  logic       RefReq,
    input  logic       RefUrg,
    input  logic       BACT,
    input  logic       RAMCS,
    output logic       nRASref,
    output logic       nCASref,
    output logic       RefActive,
    output logic       RAMHold,
    output logic       RefDone,
    output logic [7:0] RefMiss
);

    ref_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nras_q, nras_d;
    logic             ncas_q, ncas_d;
    logic             active_q, active_d;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
    logic             pending;
    logic             ramidle;

    assign pending = RefReq && !done_q;
    assign ramidle = !(BACT && RAMCS);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE: begin
                if (!RefReq) begin
                    done_d = 1'b0;
                end else if (pending && (!BACT || (RefUrg && ramidle))) begin
                    state_d = CAS;
                    cnt_d   = phase_load(CAS_SETUP);
                end else if (pending && RefUrg) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A closed window abandons the wait rather than refreshing outside it.
                if (!RefReq) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else if (ramidle) begin
                    state_d = CAS;
                    cnt_d   = phase_load(CAS_SETUP);
                end
            end
            CAS: begin
                if (cnt_q == '0) begin
                    state_d = RAS;
                    cnt_d   = phase_load(RAS_LOW);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RAS: begin
                if (cnt_q == '0) begin
                    state_d = PRE;
                    cnt_d   = phase_load(RAS_PRE);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PRE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of the next state's decode.
        ncas_d   = !(state_d == CAS || state_d == RAS);
        nras_d   = !(state_d == RAS);
        active_d = (state_d == CAS) || (state_d == RAS) || (state_d == PRE);
        hold_d   = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge nPOR) begin
        if (!nPOR) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            nras_q   <= 1'b1;
            ncas_q   <= 1'b1;
            active_q <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nras_q   <= nras_d;
            ncas_q   <= ncas_d;
            active_q <= active_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
        end
    end

    assign nRASref   = nras_q;
    assign nCASref   = ncas_q;
    assign RefActive = active_q;
    assign RAMHold   = hold_q;
    assign RefDone   = done_q;

`ifdef REF_MISS_CNT_EN
    logic miss_ok;

    assign miss_ok = (state_q == IDLE || state_q == WAIT) && !done_q;

    ref_miss_cnt u_miss_cnt (
        .clk        (CLK),
        .rst_n      (nPOR),
        .ref_req_i  (RefReq),
        .miss_ok_i  (miss_ok),
        .miss_cnt_o (RefMiss)
    );
`else
    assign RefMiss = '0;
`endif

endmodule

// File: tb/tb_ref_ctl.sv
// Self-checking bench for ref_ctl: directed scenarios plus randomized traffic against a cycle-position model.
module tb_ref_ctl;

    localparam int CS      = 1;
    localparam int RL      = 3;
    localparam int RP      = 2;
    localparam int SEQ_LEN = CS + RL + RP;

`ifdef REF_MISS_CNT_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       nPOR = 1'b0;
    logic       RefReq = 1'b0;
    logic       RefUrg = 1'b0;
    logic       BACT = 1'b0;
    logic       RAMCS = 1'b0;
    logic       nRASref, nCASref, RefActive, RAMHold, RefDone;
    logic [7:0] RefMiss;
    logic [4:0] dut_v;

    int checks = 0;
    int errors = 0;

    // Model: position within the refresh sequence (-1 when none), waiting flag, done flag, miss count.
    int m_pos      = -1;
    bit m_wait     = 1'b0;
    bit m_done     = 1'b0;
    int m_miss     = 0;
    bit m_req_prev = 1'b0;

    ref_ctl #(.CAS_SETUP(CS), .RAS_LOW(RL), .RAS_PRE(RP)) dut (
        .CLK       (CLK),
        .nPOR      (nPOR),
        .RefReq    (RefReq),
        .RefUrg    (RefUrg),
        .BACT      (BACT),
        .RAMCS     (RAMCS),
        .nRASref   (nRASref),
        .nCASref   (nCASref),
        .RefActive (RefActive),
        .RAMHold   (RAMHold),
        .RefDone   (RefDone),
        .RefMiss   (RefMiss)
    );

    always #5 CLK = ~CLK;

    assign dut_v = {nRASref, nCASref, RefActive, RAMHold, RefDone};

    function automatic logic [4:0] exp_v();
        bit ncas, nras, act, hold;
        ncas = !(m_pos >= 0 && m_pos < CS + RL);
        nras = !(m_pos >= CS && m_pos < CS + RL);
        act  = (m_pos >= 0);
        hold = (m_pos >= 0) || m_wait;
        return {nras, ncas, act, hold, m_done};
    endfunction

    task automatic model_reset();
        m_pos      = -1;
        m_wait     = 1'b0;
        m_done     = 1'b0;
        m_miss     = 0;
        m_req_prev = 1'b0;
    endtask

    task automatic model_step();
        bit ramidle;
        ramidle = !(BACT && RAMCS);
        if (MISS_EN && m_req_prev && !RefReq && m_pos < 0 && !m_done && m_miss < 255)
            m_miss++;
        if (m_pos >= 0) begin
            m_pos++;
            if (m_pos == SEQ_LEN) begin
                m_pos  = -1;
                m_done = 1'b1;
            end
        end else if (m_wait) begin
            if (!RefReq) begin
                m_wait = 1'b0;
                m_done = 1'b0;
            end else if (ramidle) begin
                m_wait = 1'b0;
                m_pos  = 0;
            end
        end else if (!RefReq) begin
            m_done = 1'b0;
        end else if (!m_done && (!BACT || (RefUrg && ramidle))) begin
            m_pos = 0;
        end else if (!m_done && RefUrg) begin
            m_wait = 1'b1;
        end
        m_req_prev = RefReq;
    endtask

    task automatic drive(input bit req, input bit urg, input bit bact, input bit ramcs);
        @(negedge CLK);
        RefReq = req;
        RefUrg = urg;
        BACT   = bact;
        RAMCS  = ramcs;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (nPOR) model_step();
        #1;
    endtask

    task automatic test_reset();
        nPOR = 1'b0;
        model_reset();
        #12;
        checks++;
        if (dut_v !== 5'b11000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", dut_v, 5'b11000);
        end
        checks++;
        if (RefMiss !== 8'd0) begin
            errors++;
            $display("FAIL reset_miss: got %0d expected 0", RefMiss);
        end
        @(negedge CLK);
        nPOR = 1'b1;
    endtask

    task automatic test_idle_refresh();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (dut_v !== exp_v()) begin
                errors++;
                $display("FAIL idle_refresh cyc%0d: got %b expected %b", i, dut_v, exp_v());
            end
        end
        // Independent spot checks: 6 cycles after entry RefDone is set and no second sequence runs.
        checks++;
        if (!(RefDone === 1'b1 && nCASref === 1'b1 && RefActive === 1'b0)) begin
            errors++;
            $display("FAIL idle_no_repeat: got done=%b ncas=%b act=%b expected 1 1 0", RefDone, nCASref, RefActive);
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dut_v !== exp_v()) begin
                errors++;
                $display("FAIL idle_close cyc%0d: got %b expected %b", i, dut_v, exp_v());
            end
        end
    endtask

    task automatic test_urgent_ram();
        drive(1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (dut_v !== exp_v() || dut_v !== 5'b11010) begin
                errors++;
                $display("FAIL urgent_wait cyc%0d: got %b expected %b", i, dut_v, 5'b11010);
            end
        end
        drive(1, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (dut_v !== exp_v() || (i == 0 && nCASref !== 1'b0)) begin
                errors++;
                $display("FAIL urgent_ram cyc%0d: got %b expected %b", i, dut_v, exp_v());
            end
        end
        drive(0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_urgent_io();
        drive(1, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (dut_v !== exp_v() || (i == 0 && dut_v !== 5'b10110)) begin
                errors++;
                $display("FAIL urgent_io cyc%0d: got %b expected %b", i, dut_v, exp_v());
            end
        end
        drive(0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_missed_window();
        drive(1, 0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (dut_v !== exp_v() || dut_v !== 5'b11000) begin
                errors++;
                $display("FAIL missed_idle cyc%0d: got %b expected %b", i, dut_v, 5'b11000);
            end
        end
        drive(0, 0, 1, 1);
        tick();
        checks++;
        if (RefMiss !== (MISS_EN ? 8'd1 : 8'd0) || RefMiss !== 8'(m_miss)) begin
            errors++;
            $display("FAIL missed_count: got %0d expected %0d", RefMiss, MISS_EN ? 1 : 0);
        end
        drive(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_close_mid_refresh();
        drive(1, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (dut_v !== exp_v()) begin
                errors++;
                $display("FAIL close_mid cyc%0d: got %b expected %b", i, dut_v, exp_v());
            end
        end
        checks++;
        if (RefDone !== 1'b0 || RefMiss !== (MISS_EN ? 8'd1 : 8'd0)) begin
            errors++;
            $display("FAIL close_mid_end: got done=%b miss=%0d expected done=0 miss=%0d", RefDone, RefMiss, MISS_EN ? 1 : 0);
        end
        drive(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (dut_v !== exp_v()) begin
                errors++;
                $display("FAIL next_window cyc%0d: got %b expected %b", i, dut_v, exp_v());
            end
        end
        drive(0, 0, 0, 0);
        tick();
        tick();
    endtask

    task automatic test_random();
        bit req = 1'b0;
        bit urg = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (!req) begin
                req = ($urandom_range(7) == 0);
                urg = 1'b0;
            end else begin
                req = ($urandom_range(11) != 0);
                if (!urg) urg = ($urandom_range(5) == 0);
            end
            drive(req, req && urg, $urandom_range(1) == 1, $urandom_range(1) == 1);
            tick();
            checks++;
            if (dut_v !== exp_v() || RefMiss !== 8'(m_miss)) begin
                errors++;
                $display("FAIL random cyc%0d: got %b/%0d expected %b/%0d", i, dut_v, RefMiss, exp_v(), m_miss);
            end
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < SEQ_LEN + 2; i++) tick();
    endtask

    task automatic test_reset_mid_ras();
        drive(1, 0, 0, 0);
        tick();
        tick();
        checks++;
        if (nRASref !== 1'b0 || dut_v !== exp_v()) begin
            errors++;
            $display("FAIL pre_reset_ras: got %b expected %b", dut_v, exp_v());
        end
        #2;
        nPOR = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_v !== 5'b11000) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", dut_v, 5'b11000);
        end
        @(negedge CLK);
        nPOR = 1'b1;
        tick();
        checks++;
        if (dut_v !== exp_v() || nCASref !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected %b", dut_v, exp_v());
        end
        drive(0, 0, 0, 0);
        for (int i = 0; i < SEQ_LEN + 1; i++) tick();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            drive(1, 0, 1, 1);
            tick();
            drive(0, 0, 1, 1);
            tick();
        end
        checks++;
        if (RefMiss !== (MISS_EN ? 8'd255 : 8'd0) || RefMiss !== 8'(m_miss)) begin
            errors++;
            $display("FAIL saturate: got %0d expected %0d", RefMiss, MISS_EN ? 255 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_idle_refresh();
        test_urgent_ram();
        test_urgent_io();
        test_missed_window();
        test_close_mid_refresh();
        test_random();
        test_reset_mid_ras();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
